// File: rtl/flex_fifo_if.sv
// Request/status bundle of flex_fifo: the host side drives the requests, the FIFO drives data and status.
// Push/pop contract: a push is taken when push && (!is_full || pop), a pop when pop && !is_empty; the rest are rejected.
interface flex_fifo_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
);
  localparam int OCP_W = $clog2(DEPTH) + 1;

  logic              clear;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] dat_in;
  logic [DATA_W-1:0] dat_out;
  logic              is_full;
  logic              is_empty;
  logic              almost_full;
  logic              almost_empty;
  logic [OCP_W-1:0]  ocp;
  logic              overflow;
  logic              underflow;

  modport master (
    output clear, push, pop, dat_in,
    input  dat_out, is_full, is_empty, almost_full, almost_empty, ocp, overflow, underflow
  );

  modport slave (
    input  clear, push, pop, dat_in,
    output dat_out, is_full, is_empty, almost_full, almost_empty, ocp, overflow, underflow
  );
endinterface

// File: rtl/flex_fifo.sv
// Parametrised synchronous FIFO with registered or first-word-fall-through read,
// programmable almost thresholds, synchronous flush and registered overflow/underflow pulses.
module flex_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  flex_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCP_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [OCP_W-1:0]  ocp_q;
  logic              overflow_q;
  logic              underflow_q;
  logic              full;
  logic              empty;
  logic              push_ok;
  logic              pop_ok;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (ocp_q == OCP_W'(DEPTH));
  assign empty   = (ocp_q == '0);
  assign push_ok = bus.push && (!full || bus.pop);
  assign pop_ok  = bus.pop && !empty;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wptr        <= '0;
      rptr        <= '0;
      ocp_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.clear) begin
      wptr        <= '0;
      rptr        <= '0;
      ocp_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok) wptr <= ptr_inc(wptr);
      if (pop_ok)  rptr <= ptr_inc(rptr);
      if (push_ok && !pop_ok)      ocp_q <= ocp_q + OCP_W'(1);
      else if (pop_ok && !push_ok) ocp_q <= ocp_q - OCP_W'(1);
      overflow_q  <= bus.push && full && !bus.pop;
      underflow_q <= bus.pop && empty;
    end
  end

  // Storage is deliberately left unreset; occupancy alone defines valid contents.
  always_ff @(posedge CLK) begin
    if (nRST && !bus.clear && push_ok) mem[wptr] <= bus.dat_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.dat_out = empty ? '0 : mem[rptr];
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                   dout_q <= '0;
        else if (!bus.clear && pop_ok) dout_q <= mem[rptr];
      end
      assign bus.dat_out = dout_q;
    end
  endgenerate

  assign bus.ocp          = ocp_q;
  assign bus.is_full      = full;
  assign bus.is_empty     = empty;
  assign bus.almost_full  = (ocp_q >= OCP_W'(AF_THRESH));
  assign bus.almost_empty = (ocp_q <= OCP_W'(AE_THRESH));
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: doc/flex_fifo.md
# flex_fifo

Parametrised synchronous FIFO that succeeds the fixed-width `FIFO_if` FIFO used between systolic-array processing elements and the DSP front end. It generalises data width and depth, and adds a selectable first-word-fall-through (FWFT) read mode. It also adds programmable almost-full/almost-empty thresholds, a synchronous flush, and overflow/underflow error pulses. It buffers operand and result streams between PE rows and the host-side load/store logic.

## Interface
Parameters:
- `DATA_W`, 32: data word width in bits.
- `DEPTH`, 16: number of entries. Must be at least 2; need not be a power of two.
- `AF_THRESH`, `DEPTH-2`: `almost_full` asserts when `ocp >= AF_THRESH`. Legal range is 1..DEPTH.
- `AE_THRESH`, 2: `almost_empty` asserts when `ocp <= AE_THRESH`. Legal range is 0..DEPTH-1.
- `FWFT`, 0: read mode. 0 selects standard registered read; 1 selects first-word-fall-through.

Ports:
- `CLK`, in, 1: clock. All state changes on the rising edge.
- `nRST`, in, 1: asynchronous active-low reset.
- `clear`, in, 1: synchronous flush.
- `push`, in, 1: write request.
- `pop`, in, 1: read request.
- `dat_in`, in, DATA_W: write data.
- `dat_out`, out, DATA_W: read data.
- `is_full`, out, 1: asserted when `ocp == DEPTH`.
- `is_empty`, out, 1: asserted when `ocp == 0`.
- `almost_full`, out, 1: asserted when `ocp >= AF_THRESH`.
- `almost_empty`, out, 1: asserted when `ocp <= AE_THRESH`.
- `ocp`, out, $clog2(DEPTH)+1: current occupancy.
- `overflow`, out, 1: one-cycle pulse when a push is rejected.
- `underflow`, out, 1: one-cycle pulse when a pop is rejected.

## Operation
- Storage is a DEPTH-entry array with write pointer `wptr` and read pointer `rptr`, each 0..DEPTH-1. Each pointer wraps from DEPTH-1 to 0. `ocp` is a separate registered counter.
- A push is accepted when `push && (!is_full || pop)`. An accepted push writes `dat_in` to `mem[wptr]` and advances `wptr`.
- A pop is accepted when `pop && !is_empty`. An accepted pop advances `rptr`.
- Full with push and pop together: both are accepted and `ocp` is unchanged.
- Empty with push and pop together: only the push is accepted, and `underflow` pulses.
- Rejected push: `push && is_full && !pop` pulses `overflow` for one cycle. Memory and pointers are unchanged.
- Rejected pop: `pop && is_empty` pulses `underflow` for one cycle.
- `ocp` next value: +1 for a push alone, -1 for a pop alone, unchanged for both or neither.
- `clear` has priority over `push` and `pop`. It zeroes `wptr`, `rptr` and `ocp`, and suppresses `overflow`/`underflow` that cycle. Memory contents are not cleared. In standard mode `dat_out` holds its value.
- All flags are decoded from the registered `ocp` and registered flag state, never from `push`/`pop` directly.
- Standard mode (FWFT=0): `dat_out` is a register. It loads `mem[rptr]` on an accepted pop and holds otherwise.
- FWFT mode (FWFT=1): `dat_out` equals `mem[rptr]` whenever `!is_empty`. When empty, `dat_out` is 0. `pop` acknowledges the word currently shown.
- Reset values:
  - `ocp`, `wptr`, `rptr`: 0.
  - `is_empty`, `almost_empty`: 1.
  - `is_full`, `almost_full`, `overflow`, `underflow`, `dat_out`: 0.
  - Memory is not reset.
- A reset mid-operation discards all contents immediately, with no completion of any in-flight push or pop.

## Timing
- A push accepted at edge N is reflected in `ocp` and the flags after edge N.
- Standard-mode read latency is 1 cycle: a pop accepted at edge N presents data on `dat_out` after edge N.
- FWFT: a push into an empty FIFO at edge N makes the word visible on `dat_out` and deasserts `is_empty` after edge N. There is no extra bubble.
- FWFT: after a pop at edge N, the next word, or 0 if the FIFO is now empty, is visible after edge N.
- `overflow` and `underflow` are registered. A request rejected at edge N produces a pulse for the single cycle following edge N.
- Sustained push and pop every cycle in a non-empty, non-full FIFO gives throughput of 1 word per cycle with `ocp` constant.

## Test plan
All scenarios use DATA_W=32, DEPTH=4, AF_THRESH=3, AE_THRESH=1.
- Reset with `nRST`=0 mid-stream with 3 words held -> `ocp`=0, `is_empty`=1, `almost_empty`=1, `dat_out`=0, all other flags 0.
- FWFT=0: push 0xA1, 0xB2, 0xC3, 0xD4 -> `is_full`=1 and `almost_full`=1 after the 4th edge. A 5th push of 0xE5 -> `overflow` pulses for 1 cycle and `ocp` stays 4. Four pops -> `dat_out` shows 0xA1..0xD4, each 1 cycle after its pop. A 5th pop -> `underflow` pulse.
- Wrap-around: run 10 interleaved push/pop pairs with values 1..10 at `ocp`=2 -> outputs are in order with no loss, `ocp` stays 2, no error pulses.
- Simultaneous push and pop at full with new value 0x55 -> `ocp` stays 4 and 0x55 is read out last. Simultaneous push and pop at empty -> `ocp`=1 and `underflow` pulses.
- FWFT=1: push 0x1234 into an empty FIFO -> `dat_out`=0x1234 and `is_empty`=0 on the next cycle with no pop. Pop -> `dat_out`=0 and `is_empty`=1.
- `clear` asserted with push and pop at `ocp`=3 -> `ocp`=0, `is_empty`=1, no error pulse. A following push of 0x77 is the next word read.
